fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequences instruction fetch: drives if_stage PC control and an instruction-memory request/grant/rvalid port.
//  Hands fetched words to ID over a valid/ready handshake and applies branch/jump redirects from EX.
//  Stale responses from redirected fetches are discarded. A hung memory raises a sticky error.
//  Sits between if_stage (pc_o), imem and the IF/ID register. Single outstanding request.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles in WAIT/DROP before fetch_err_o; 0 disables timeout
// PORTS
//  clk              in   1   clock
//  rst              in   1   synchronous, active-high reset
//  pc_i             in   32  current PC from if_stage pc_o
//  pc_stall_o       out  1   to if_stage pc_stall_i; 0 only on advance or redirect
//  pc_src_o         out  1   to if_stage pc_src_i; 1 = load branch_target_o
//  branch_target_o  out  32  to if_stage branch_target_i
//  redirect_i       in   1   EX: taken branch/jump this cycle
//  redirect_pc_i    in   32  EX: redirect target
//  imem_req_o       out  1   fetch request
//  imem_addr_o      out  32  fetch address (= pc_i)
//  imem_gnt_i       in   1   request accepted this cycle
//  imem_rvalid_i    in   1   response valid, exactly one per granted request
//  imem_rdata_i     in   32  response instruction
//  instr_valid_o    out  1   instruction to ID valid
//  instr_o          out  32  instruction to ID
//  instr_pc_o       out  32  PC of instr_o
//  id_ready_i       in   1   ID accepts
//  fetch_err_o      out  1   sticky: imem timeout
// BEHAVIOUR
//  Reset (rst at posedge): state=IDLE; instr_valid_o=0, instr_o=0, instr_pc_o=0, imem_req_o=0, fetch_err_o=0,
//   timeout counter=0. Reset mid-transfer abandons it; a late rvalid after reset is ignored (state != WAIT).
//  States: IDLE, REQ, WAIT, VALID, DROP, HALT. IDLE -> REQ unconditionally next cycle.
//  REQ: imem_req_o=1, imem_addr_o=pc_i. gnt -> WAIT (latch pc_i as fetch PC). No gnt -> stay REQ.
//  WAIT: rvalid -> register rdata/fetch PC into instr_o/instr_pc_o, instr_valid_o=1 next cycle, -> VALID.
//  VALID: instr_valid_o=1, outputs stable until id_ready_i. On handshake: pc_stall_o=0, pc_src_o=0 (PC+4),
//   instr_valid_o=0 next cycle, -> REQ. Min latency req->instr_valid_o = 2 cycles (gnt same cycle, rvalid next).
//  Redirect (any state except HALT/IDLE): pc_stall_o=0, pc_src_o=1, branch_target_o=redirect_pc_i that cycle;
//   redirect has priority over ID handshake and gnt-less request.
//   REQ, no gnt: -> REQ (new PC next cycle; only case req may change address before gnt).
//   REQ with gnt same cycle: -> DROP.   WAIT, no rvalid: -> DROP.   WAIT with rvalid same cycle: data discarded, -> REQ.
//   VALID: instruction discarded (instr_valid_o=0 next cycle even if id_ready_i=1), -> REQ.
//   DROP: stays DROP (PC still updated).
//  DROP: imem_req_o=0; rvalid discarded, -> REQ. Redirect and rvalid same cycle -> REQ (new PC).
//  All other cycles: pc_stall_o=1, pc_src_o=0; branch_target_o=redirect_pc_i always (don't-care when pc_src_o=0).
//  Timeout: counter increments each cycle in WAIT or DROP without rvalid, clears on leaving them;
//   on reaching TIMEOUT_CYCLES: fetch_err_o=1 next cycle (sticky), -> HALT. Counter width $clog2(TIMEOUT_CYCLES+1), saturating.
//  HALT: imem_req_o=0, instr_valid_o=0, pc_stall_o=1, redirects ignored; exit only by rst.
//  pc_i assumed word-aligned; no alignment check here.
// TESTING
//  1 rst 2 cycles, pc_i=0x0000_0000 -> outputs 0; cycle after IDLE imem_req_o=1, imem_addr_o=0x0.
//  2 gnt immediate, rvalid next, id_ready_i=1, rdata 0x00000013 -> instr_valid_o 2 cycles after req, instr_pc_o=0x0; 4 fetches 0x0..0xC, pc_stall_o low once per fetch.
//  3 id_ready_i=0 for 5 cycles in VALID -> instr_o/instr_pc_o/instr_valid_o stable, pc_stall_o=1, imem_req_o=0; release -> one handshake.
//  4 redirect_i=1, redirect_pc_i=0x80 in WAIT, rvalid 3 cycles later with 0xDEADBEEF -> never on instr_o; next req addr=0x80.
//  5 redirect in VALID with id_ready_i=1 -> no handshake, pc_src_o=1, next fetch at target; redirect with gnt in REQ -> DROP.
//  6 TIMEOUT_CYCLES=8, gnt then no rvalid -> fetch_err_o=1 after 8 WAIT cycles, HALT; rst mid-WAIT then stray rvalid -> ignored, clean restart.

Source files
------------

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//   Instruction fetch sequencer. Steers the if_stage PC register (stall /
//   load-target / advance), issues one instruction-memory request at a time
//   on a req/gnt/rvalid port and hands each fetched word to ID. Branch/jump
//   redirects from EX are applied immediately. Responses belonging to a fetch
//   that was overtaken by a redirect are swallowed. A memory that never
//   answers raises a sticky error and parks the block until reset.
//
// Handshakes
//   imem: a request is accepted in the cycle imem_req_o && imem_gnt_i. Exactly
//     one imem_rvalid_i pulse follows each accepted request, no earlier than
//     the next cycle. Only one request is ever outstanding.
//   ID:   an instruction transfers in the cycle instr_valid_o && id_ready_i,
//     unless redirect_i is high in that same cycle (the redirect wins and the
//     instruction is thrown away). While instr_valid_o is high and no transfer
//     happens, instr_o / instr_pc_o hold their values.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   pc_i             current PC from if_stage
//   pc_stall_o       hold the PC (low only on ID transfer or redirect)
//   pc_src_o         1 = if_stage loads branch_target_o instead of PC+4
//   branch_target_o  redirect target (always mirrors redirect_pc_i)
//   redirect_i       EX taken branch/jump this cycle
//   redirect_pc_i    EX redirect target
//   imem_req_o       fetch request
//   imem_addr_o      fetch address (= pc_i)
//   imem_gnt_i       request accepted
//   imem_rvalid_i    response valid
//   imem_rdata_i     response word
//   instr_valid_o    instruction to ID valid
//   instr_o          instruction to ID
//   instr_pc_o       PC of instr_o
//   id_ready_i       ID accepts
//   fetch_err_o      sticky memory-timeout flag
//   state_dbg        current FSM state (debug observation only)
// ---------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  output logic        pc_stall_o,
  output logic        pc_src_o,
  output logic [31:0] branch_target_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        id_ready_i,
  output logic        fetch_err_o,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_DROP  = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  // A zero TIMEOUT_CYCLES disables the timeout; keep a 1-bit counter so the
  // declarations stay legal in that case.
  localparam bit          TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam int          CW      = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] to_cnt;

  logic redirect_eff;
  logic handshake;
  logic count_cycle;
  logic timeout_hit;

  // Redirects are meaningless before the first request and once halted.
  assign redirect_eff = redirect_i && (state != S_IDLE) && (state != S_HALT);
  // A redirect in VALID kills the instruction, so it is not a transfer.
  assign handshake    = (state == S_VALID) && id_ready_i && !redirect_i;
  assign count_cycle  = ((state == S_WAIT) || (state == S_DROP)) && !imem_rvalid_i;
  // to_cnt already holds the number of earlier waiting cycles, so the cycle
  // that finds it at TIMEOUT_CYCLES-1 is the TIMEOUT_CYCLES-th one.
  assign timeout_hit  = TO_EN && count_cycle && (to_cnt == TO_LAST);

  assign pc_stall_o      = !(redirect_eff || handshake);
  assign pc_src_o        = redirect_eff;
  assign branch_target_o = redirect_pc_i;
  assign imem_req_o      = (state == S_REQ);
  assign imem_addr_o     = pc_i;
  assign state_dbg       = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      fetch_pc      <= '0;
      instr_valid_o <= 1'b0;
      instr_o       <= '0;
      instr_pc_o    <= '0;
      fetch_err_o   <= 1'b0;
      to_cnt        <= '0;
    end else begin
      // Saturating wait counter; only runs while a response is outstanding.
      if (count_cycle) begin
        if (to_cnt != {CW{1'b1}}) to_cnt <= to_cnt + CW'(1);
      end else begin
        to_cnt <= '0;
      end

      if (timeout_hit) begin
        fetch_err_o <= 1'b1;
        state       <= S_HALT;
      end else begin
        case (state)
          S_IDLE: state <= S_REQ;

          S_REQ: begin
            if (redirect_i) begin
              // A grant in the redirect cycle means a stale response is coming.
              state <= imem_gnt_i ? S_DROP : S_REQ;
            end else if (imem_gnt_i) begin
              fetch_pc <= pc_i;
              state    <= S_WAIT;
            end
          end

          S_WAIT: begin
            if (redirect_i) begin
              state <= imem_rvalid_i ? S_REQ : S_DROP;
            end else if (imem_rvalid_i) begin
              instr_o       <= imem_rdata_i;
              instr_pc_o    <= fetch_pc;
              instr_valid_o <= 1'b1;
              state         <= S_VALID;
            end
          end

          S_VALID: begin
            if (redirect_i || id_ready_i) begin
              instr_valid_o <= 1'b0;
              state         <= S_REQ;
            end
          end

          S_DROP: begin
            if (imem_rvalid_i) state <= S_REQ;
          end

          S_HALT: state <= S_HALT;

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
//   Directed scenarios (reset, back-to-back fetches, ID back-pressure,
//   redirects in WAIT/VALID/REQ, stale response drop, timeout/HALT, reset
//   mid-transfer) followed by a randomized phase checked against an
//   architectural model: the PC stream ID must see, kept in exp_q.
//   The bench also plays if_stage (pc_i register) and the instruction memory.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_stall_o;
  logic        pc_src_o;
  logic [31:0] branch_target_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        id_ready_i;
  logic        fetch_err_o;
  logic [2:0]  state_dbg;

  fetch_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_i            (pc_i),
    .pc_stall_o      (pc_stall_o),
    .pc_src_o        (pc_src_o),
    .branch_target_o (branch_target_o),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .instr_valid_o   (instr_valid_o),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o),
    .id_ready_i      (id_ready_i),
    .fetch_err_o     (fetch_err_o),
    .state_dbg       (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_cmp;
  int          n_fail;
  int          stall_lows;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // ---------------- driver tasks ----------------
  // One clock: the bench's if_stage register follows pc_stall/pc_src, then
  // single-cycle inputs drop back to idle 1 ns after the edge.
  task automatic advance();
    logic [31:0] np;
    if (!pc_stall_o) stall_lows++;
    np = pc_stall_o ? pc_i : (pc_src_o ? branch_target_o : pc_i + 32'd4);
    @(posedge clk);
    #1;
    pc_i          = rst ? 32'h0 : np;
    redirect_i    = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    id_ready_i    = 1'b0;
  endtask

  // Fastest possible fetch starting in REQ: gnt now, rvalid next, ID ready.
  task automatic fetch_fast(input logic [31:0] pc, input logic [31:0] data);
    imem_gnt_i = 1'b1;
    #1;
    chk("ff_req", imem_req_o, 1);
    chk("ff_addr", imem_addr_o, pc);
    chk("ff_stall_req", pc_stall_o, 1);
    advance();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = data;
    #1;
    chk("ff_valid_wait", instr_valid_o, 0);
    chk("ff_req_wait", imem_req_o, 0);
    advance();
    id_ready_i = 1'b1;
    #1;
    chk("ff_valid", instr_valid_o, 1);
    chk("ff_instr", instr_o, data);
    chk("ff_instr_pc", instr_pc_o, pc);
    chk("ff_stall_hs", pc_stall_o, 0);
    chk("ff_src_hs", pc_src_o, 0);
    advance();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          snap;
    int          delivered;
    int          gap;
    int          max_gap;
    logic        pend;
    logic [31:0] pend_addr;
    int          pend_dly;
    logic [31:0] nxt;

    n_cmp = 0; n_fail = 0; stall_lows = 0;
    rst = 1'b1; pc_i = 32'h0;
    redirect_i = 1'b0; redirect_pc_i = 32'h0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    id_ready_i = 1'b0;

    // 1: reset for two cycles, then IDLE, then REQ at 0x0
    advance();
    advance();
    #1;
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_instr_pc", instr_pc_o, 32'h0);
    chk("rst_req", imem_req_o, 0);
    chk("rst_err", fetch_err_o, 0);
    rst = 1'b0;
    #1;
    chk("idle_req", imem_req_o, 0);
    chk("idle_stall", pc_stall_o, 1);
    advance();
    #1;
    chk("first_req", imem_req_o, 1);
    chk("first_addr", imem_addr_o, 32'h0);

    // 2: four back-to-back fetches 0x0..0xC
    snap = stall_lows;
    for (int i = 0; i < 4; i++) fetch_fast(32'(i * 4), 32'h0000_0013);
    chk("stall_low_count", 32'(stall_lows - snap), 4);

    // 3: ID back-pressure for 5 cycles at 0x10
    imem_gnt_i = 1'b1;
    advance();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h00A0_0093;
    advance();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", instr_valid_o, 1);
      chk("bp_instr", instr_o, 32'h00A0_0093);
      chk("bp_instr_pc", instr_pc_o, 32'h10);
      chk("bp_stall", pc_stall_o, 1);
      chk("bp_req", imem_req_o, 0);
      advance();
    end
    id_ready_i = 1'b1;
    #1;
    chk("bp_release_stall", pc_stall_o, 0);
    advance();
    #1;
    chk("bp_after_valid", instr_valid_o, 0);
    chk("bp_after_addr", imem_addr_o, 32'h14);

    // 4: redirect in WAIT, stale response arrives 3 cycles later
    imem_gnt_i = 1'b1;
    advance();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h80;
    #1;
    chk("rw_stall", pc_stall_o, 0);
    chk("rw_src", pc_src_o, 1);
    chk("rw_target", branch_target_o, 32'h80);
    advance();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
      end
      #1;
      chk("drop_req", imem_req_o, 0);
      chk("drop_valid", instr_valid_o, 0);
      advance();
    end
    #1;
    chk("rw_valid_after", instr_valid_o, 0);
    chk("rw_new_addr", imem_addr_o, 32'h80);
    fetch_fast(32'h80, 32'h0000_0513);

    // 5a: redirect in VALID with ID ready -> no transfer
    imem_gnt_i = 1'b1;
    advance();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h1111_0113;
    advance();
    id_ready_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    #1;
    chk("rv_valid", instr_valid_o, 1);
    chk("rv_instr_pc", instr_pc_o, 32'h84);
    chk("rv_src", pc_src_o, 1);
    chk("rv_stall", pc_stall_o, 0);
    chk("rv_target", branch_target_o, 32'h100);
    advance();
    #1;
    chk("rv_valid_next", instr_valid_o, 0);
    chk("rv_addr_next", imem_addr_o, 32'h100);
    // 5b: redirect together with gnt in REQ -> stale response dropped
    imem_gnt_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h200;
    #1;
    chk("rg_src", pc_src_o, 1);
    advance();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0BAD_0BAD;
    #1;
    chk("rg_drop_req", imem_req_o, 0);
    advance();
    #1;
    chk("rg_valid", instr_valid_o, 0);
    chk("rg_addr", imem_addr_o, 32'h200);
    // 5c: redirect in REQ without gnt -> new address next cycle
    redirect_i = 1'b1;
    redirect_pc_i = 32'h300;
    #1;
    chk("rr_src", pc_src_o, 1);
    advance();
    #1;
    chk("rr_req", imem_req_o, 1);
    chk("rr_addr", imem_addr_o, 32'h300);
    fetch_fast(32'h300, 32'h0030_0313);

    // 6: timeout after 8 WAIT cycles, HALT ignores redirects
    imem_gnt_i = 1'b1;
    advance();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("to_err_early", fetch_err_o, 0);
      advance();
    end
    #1;
    chk("to_err", fetch_err_o, 1);
    chk("halt_req", imem_req_o, 0);
    chk("halt_valid", instr_valid_o, 0);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h400;
    #1;
    chk("halt_stall", pc_stall_o, 1);
    chk("halt_src", pc_src_o, 0);
    advance();
    advance();
    #1;
    chk("halt_err_sticky", fetch_err_o, 1);
    chk("halt_req_late", imem_req_o, 0);
    // reset out of HALT, then reset mid-WAIT with a stray rvalid
    rst = 1'b1;
    advance();
    rst = 1'b0;
    #1;
    chk("rst2_err", fetch_err_o, 0);
    advance();
    imem_gnt_i = 1'b1;
    advance();
    rst = 1'b1;
    advance();
    rst = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hBADB_AD00;
    #1;
    chk("stray_req", imem_req_o, 0);
    advance();
    #1;
    chk("stray_valid", instr_valid_o, 0);
    chk("restart_req", imem_req_o, 1);
    chk("restart_addr", imem_addr_o, 32'h0);
    fetch_fast(32'h0, 32'h0000_0013);

    // Randomized phase against the architectural PC-stream model
    exp_q.delete();
    exp_q.push_back(32'h4);
    pend = 1'b0; pend_addr = 32'h0; pend_dly = 0;
    delivered = 0; gap = 0; max_gap = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (pend) begin
        if (pend_dly == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = mem_word(pend_addr);
          pend = 1'b0;
        end else begin
          pend_dly--;
        end
      end
      id_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        redirect_i    = 1'b1;
        redirect_pc_i = $urandom & 32'h0000_FFFC;
      end
      if (imem_req_o && !pend && !imem_rvalid_i && ($urandom_range(0, 1) == 1)) begin
        imem_gnt_i = 1'b1;
        pend       = 1'b1;
        pend_addr  = imem_addr_o;
        pend_dly   = $urandom_range(0, 3);
      end
      #1;
      if (imem_gnt_i) chk("rnd_addr", imem_addr_o, exp_q[0]);
      if (instr_valid_o) begin
        chk("rnd_instr_pc", instr_pc_o, exp_q[0]);
        chk("rnd_instr", instr_o, mem_word(exp_q[0]));
      end
      if (redirect_i) begin
        chk("rnd_redir_stall", pc_stall_o, 0);
        chk("rnd_redir_src", pc_src_o, 1);
        chk("rnd_redir_target", branch_target_o, redirect_pc_i);
        exp_q.delete();
        exp_q.push_back(redirect_pc_i);
      end else if (instr_valid_o && id_ready_i) begin
        chk("rnd_hs_stall", pc_stall_o, 0);
        chk("rnd_hs_src", pc_src_o, 0);
        nxt = exp_q.pop_front() + 32'd4;
        exp_q.push_back(nxt);
        delivered++;
        gap = 0;
      end else begin
        chk("rnd_stall", pc_stall_o, 1);
      end
      chk("rnd_err", fetch_err_o, 0);
      gap++;
      if (gap > max_gap) max_gap = gap;
      advance();
    end
    chk("rnd_progress", 32'(delivered >= 20), 1);
    chk("rnd_max_gap", 32'(max_gap <= 60), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
